// File: rtl/revaluate_pkg.sv
// Shared definitions for the revaluate encoder flow: default widths, round count
// and the one-hot sequencer state encodings used by the core and writer as well.
package revaluate_pkg;

   localparam int IDX_W_DEF      = 10;
   localparam int NUM_ROUNDS_DEF = 24;
   localparam int RND_W_DEF      = 5;

   localparam int ST_W = 7;
   typedef logic [ST_W-1:0] state_t;

   // Bit positions of the one-hot state vector.
   localparam int B_IDLE  = 0;
   localparam int B_READ  = 1;
   localparam int B_LOAD  = 2;
   localparam int B_ROUND = 3;
   localparam int B_WRITE = 4;
   localparam int B_NEXT  = 5;
   localparam int B_DONE  = 6;

   localparam logic [6:0] S_IDLE  = 7'b000_0001;
   localparam logic [6:0] S_READ  = 7'b000_0010;
   localparam logic [6:0] S_LOAD  = 7'b000_0100;
   localparam logic [6:0] S_ROUND = 7'b000_1000;
   localparam logic [6:0] S_WRITE = 7'b001_0000;
   localparam logic [6:0] S_NEXT  = 7'b010_0000;
   localparam logic [6:0] S_DONE  = 7'b100_0000;

endpackage

// File: rtl/revaluate_round_counter.sv
// Round counter with synchronous clear and enable; tc flags the last round and the
// counter wraps back to 0 on the following enabled edge.
module revaluate_round_counter
   import revaluate_pkg::*;
#(
   parameter int NUM_ROUNDS = NUM_ROUNDS_DEF,
   parameter int RND_W      = RND_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             enable,
   output logic [RND_W-1:0] count,
   output logic             tc
);

   assign tc = (count == RND_W'(NUM_ROUNDS - 1));

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (clear || (enable && tc)) begin
         count <= '0;
      end else if (enable) begin
         count <= count + RND_W'(1);
      end
   end

endmodule

// File: rtl/revaluate_file_sequencer.sv
// Sequences reader -> permutation core -> writer over an inclusive file index range.
// Owns no datapath; every strobe is a single bit of the one-hot state register.
module revaluate_file_sequencer
   import revaluate_pkg::*;
#(
   parameter int IDX_W      = IDX_W_DEF,
   parameter int NUM_ROUNDS = NUM_ROUNDS_DEF,
   parameter int RND_W      = RND_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [IDX_W-1:0] first_index,
   input  logic [IDX_W-1:0] last_index,
   input  logic             write_ready,
   output logic             read_file,
   output logic [IDX_W-1:0] file_index,
   output logic             load_state,
   output logic             round_en,
   output logic [RND_W-1:0] round_idx,
   output logic             write_file,
   output logic             busy,
   output logic             done,
   output logic             range_err,
   output logic [IDX_W:0]   files_processed
);

   state_t           state_q;
   state_t           state_d;
   logic [IDX_W-1:0] last_q;
   logic             rnd_tc;
   logic             abort_run;
   logic             bad_range;

   assign abort_run = abort && !state_q[B_IDLE];
   assign bad_range = (first_index > last_index);

   // NOTE: strobes come straight from one-hot flop bits, so they are registered,
   // mutually exclusive and glitch-free without any extra output stage.
   assign read_file  = state_q[B_READ];
   assign load_state = state_q[B_LOAD];
   assign round_en   = state_q[B_ROUND];
   assign write_file = state_q[B_WRITE];
   assign done       = state_q[B_DONE];
   assign busy       = !state_q[B_IDLE];

   revaluate_round_counter #(
      .NUM_ROUNDS (NUM_ROUNDS),
      .RND_W      (RND_W)
   ) u_round_counter (
      .clk    (clk),
      .rst    (rst),
      .clear  (!state_q[B_ROUND] || abort_run),
      .enable (state_q[B_ROUND]),
      .count  (round_idx),
      .tc     (rnd_tc)
   );

   // NOTE: state_d gets a default before the case so no path leaves it unassigned
   // and no latch is inferred.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = bad_range ? S_DONE : S_READ;
         S_READ:  state_d = S_LOAD;
         S_LOAD:  state_d = S_ROUND;
         S_ROUND: if (rnd_tc) state_d = S_WRITE;
         S_WRITE: if (write_ready) state_d = S_NEXT;
         S_NEXT:  state_d = (file_index == last_q) ? S_DONE : S_READ;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // Abort outranks every other transition, including write_ready in WRITE.
      if (abort_run) state_d = S_IDLE;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_q          <= '0;
         file_index      <= '0;
         files_processed <= '0;
         range_err       <= 1'b0;
      end else if (state_q[B_IDLE] && start) begin
         last_q          <= last_index;
         files_processed <= '0;
         range_err       <= bad_range;
         if (!bad_range) file_index <= first_index;
      end else if (state_q[B_NEXT] && !abort_run) begin
         files_processed <= files_processed + (IDX_W+1)'(1);
         // Compare before incrementing so a top-of-range last index never wraps.
         if (file_index != last_q) file_index <= file_index + IDX_W'(1);
      end
   end

endmodule
